// File: rtl/cnn_pkg.sv
// cnn_pkg: shared width helpers and saturating requantisation for the conv layers
package cnn_pkg;
  localparam int MAXW = 64;
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction
  function automatic int acc_w(input int b, input int taps);
    return 2 * b + clog2(taps + 1) + 1;
  endfunction
  function automatic logic signed [MAXW-1:0] requant(input logic signed [MAXW-1:0] acc, input int frac, input logic relu, input int b);
    logic signed [MAXW-1:0] r, hi, lo;
    hi = (64'sd1 <<< (b - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r = acc >>> frac;
    r = (relu && r < 0) ? '0 : r;
    return r > hi ? hi : (r < lo ? lo : r);
  endfunction
endpackage

// File: rtl/conv_pe.sv
// conv_pe: one output channel's multiply / adder-tree / requantise pipeline
module conv_pe
  import cnn_pkg::*;
#(
  parameter int B = 8,
  parameter int TAPS = 9,
  parameter int FRAC = 0,
  parameter int RELU = 1,
  parameter int ACC = acc_w(B, TAPS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        i_en,
  input  logic [TAPS*B-1:0] i_window,
  input  logic [TAPS*B-1:0] i_weight,
  input  logic [B-1:0]      i_bias,
  output logic [B-1:0]      o_data
);
  logic signed [2*B-1:0] prod [TAPS];
  logic signed [ACC-1:0] acc, sum;
  // adder tree over the registered products, bias pre-scaled into the accumulator's fixed point
  always_comb begin
    sum = ACC'($signed(i_bias)) <<< FRAC;
    for (int t = 0; t < TAPS; t++) sum = sum + ACC'(prod[t]);
  end
  // S1: per-tap products
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) for (int t = 0; t < TAPS; t++) prod[t] <= '0;
    else if (i_en[0])
      for (int t = 0; t < TAPS; t++) prod[t] <= $signed(i_window[t*B +: B]) * $signed(i_weight[t*B +: B]);
  // S2: accumulated sum plus bias
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) acc <= '0;
    else if (i_en[1]) acc <= sum;
  // S3: requantised result, held while no new result arrives
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) o_data <= '0;
    else if (i_en[2]) o_data <= B'(requant(MAXW'(acc), FRAC, RELU != 0, B));
endmodule

// File: rtl/conv_layer_ms.sv
// conv_layer_ms: strided multi-channel conv layer with position tracking and OCH parallel PEs
module conv_layer_ms
  import cnn_pkg::*;
#(
  parameter int F = 28,
  parameter int B = 8,
  parameter int KX = 3,
  parameter int KY = 3,
  parameter int ICH = 1,
  parameter int OCH = 16,
  parameter int STRIDE = 2,
  parameter int FRAC = 0,
  parameter int RELU = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [ICH*KX*KY*B-1:0]    i_window,
  input  logic                      i_window_valid,
  input  logic                      i_sof,
  input  logic [OCH*ICH*KX*KY*B-1:0] i_weight,
  input  logic [OCH*B-1:0]          i_bias,
  output logic [OCH*B-1:0]          o_data,
  output logic                      o_valid,
  output logic                      o_last
);
  localparam int TAPS = ICH * KX * KY;
  localparam int W = F - KX + 1;
  localparam int OW = (W - 1) / STRIDE + 1;
  localparam int LP = (OW - 1) * STRIDE;
  localparam int CW = clog2(W + 1);
  logic [CW-1:0] col, row, pos_c, pos_r;
  logic [2:0] v, l, en;
  logic accept, last;
  assign pos_c = i_sof ? '0 : col;
  assign pos_r = i_sof ? '0 : row;
  assign accept = i_window_valid && (int'(pos_c) % STRIDE == 0) && (int'(pos_r) % STRIDE == 0);
  assign last = accept && pos_c == CW'(LP) && pos_r == CW'(LP);
  assign en = {v[1], v[0], accept};
  assign o_valid = v[2];
  assign o_last = l[2];
  // raster position of the next window; i_sof forces the current one to (0,0)
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      col <= '0;
      row <= '0;
    end else if (i_window_valid) begin
      col <= pos_c == CW'(W - 1) ? '0 : pos_c + CW'(1);
      row <= pos_c == CW'(W - 1) ? (pos_r == CW'(W - 1) ? '0 : pos_r + CW'(1)) : pos_r;
    end
  // valid and last tags ride alongside the three data stages
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      v <= '0;
      l <= '0;
    end else begin
      v <= {v[1:0], accept};
      l <= {l[1:0], last};
    end
  for (genvar o = 0; o < OCH; o++) begin : g_pe
    conv_pe #(.B(B), .TAPS(TAPS), .FRAC(FRAC), .RELU(RELU)) u_pe (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (en),
      .i_window(i_window),
      .i_weight(i_weight[o*TAPS*B +: TAPS*B]),
      .i_bias  (i_bias[o*B +: B]),
      .o_data  (o_data[o*B +: B])
    );
  end
endmodule

// File: tb/tb_conv_layer_ms.sv
// tb_conv_layer_ms: scoreboard bench for geometry, stride, resync, requantisation and reset
module tb_conv_layer_ms;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int a_outs = 0;
  int a_lasts = 0;
  logic [143:0] a_win;
  logic a_v, a_sof;
  logic [287:0] a_wt;
  logic [15:0] a_bias, a_data;
  logic a_valid, a_last;
  logic [7:0] q_win;
  logic q_v, q_sof;
  logic [23:0] q_wt, q_bias, q0_data, q1_data;
  logic q0_valid, q0_last, q1_valid, q1_last;
  typedef struct {
    logic [15:0] data;
    logic        last;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int mcol = 0;
  int mrow = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_layer_ms #(.F(6), .B(8), .KX(3), .KY(3), .ICH(2), .OCH(2), .STRIDE(2), .FRAC(0), .RELU(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_window(a_win), .i_window_valid(a_v), .i_sof(a_sof),
    .i_weight(a_wt), .i_bias(a_bias), .o_data(a_data), .o_valid(a_valid), .o_last(a_last));
  conv_layer_ms #(.F(3), .B(8), .KX(1), .KY(1), .ICH(1), .OCH(3), .STRIDE(1), .FRAC(1), .RELU(0)) u_q0 (
    .i_clk(clk), .i_rst(rst), .i_window(q_win), .i_window_valid(q_v), .i_sof(q_sof),
    .i_weight(q_wt), .i_bias(q_bias), .o_data(q0_data), .o_valid(q0_valid), .o_last(q0_last));
  conv_layer_ms #(.F(3), .B(8), .KX(1), .KY(1), .ICH(1), .OCH(3), .STRIDE(1), .FRAC(1), .RELU(1)) u_q1 (
    .i_clk(clk), .i_rst(rst), .i_window(q_win), .i_window_valid(q_v), .i_sof(q_sof),
    .i_weight(q_wt), .i_bias(q_bias), .o_data(q1_data), .o_valid(q1_valid), .o_last(q1_last));

  function automatic logic [15:0] model(input logic [143:0] w);
    logic [15:0] r;
    int acc;
    r = '0;
    for (int o = 0; o < 2; o++) begin
      acc = int'($signed(a_bias[o*8 +: 8]));
      for (int t = 0; t < 18; t++)
        acc += int'($signed(a_wt[(o*18+t)*8 +: 8])) * int'($signed(w[t*8 +: 8]));
      if (acc < 0) acc = 0;
      if (acc > 127) acc = 127;
      r[o*8 +: 8] = 8'(acc);
    end
    return r;
  endfunction

  function automatic logic [143:0] rand_win();
    logic [143:0] r;
    for (int t = 0; t < 18; t++) r[t*8 +: 8] = 8'($urandom_range(15)) - 8'd8;
    return r;
  endfunction

  task automatic rand_params();
    for (int t = 0; t < 36; t++) a_wt[t*8 +: 8] = 8'($urandom_range(15)) - 8'd8;
    a_bias = 16'($urandom);
  endtask

  task automatic cycle_a(input logic v, input logic s, input logic [143:0] w);
    int pc, pr;
    exp_t x;
    @(posedge clk);
    #1;
    a_v = v;
    a_sof = s;
    a_win = w;
    if (v) begin
      pc = s ? 0 : mcol;
      pr = s ? 0 : mrow;
      if (pc % 2 == 0 && pr % 2 == 0) begin
        x.data = model(w);
        x.last = (pc == 2 && pr == 2);
        x.due = cyc + 3;
        sb.push_back(x);
      end
      mcol = pc == 3 ? 0 : pc + 1;
      mrow = pc == 3 ? (pr == 3 ? 0 : pr + 1) : pr;
    end
  endtask

  task automatic drain();
    repeat (6) cycle_a(1'b0, 1'b0, '0);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
  endtask

  // scoreboard monitor for the main instance: order, data, last tag and exact arrival cycle
  always @(negedge clk)
    if (!rst) begin
      if (a_valid) begin
        a_outs++;
        if (a_last) a_lasts++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL a_unexpected data=%h last=%b cyc=%0d", a_data, a_last, cyc);
        end else begin
          e = sb.pop_front();
          if (a_data !== e.data || a_last !== e.last || cyc != e.due) begin
            failures++;
            $display("FAIL a_out got data=%h last=%b cyc=%0d required data=%h last=%b cyc=%0d",
                     a_data, a_last, cyc, e.data, e.last, e.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++;
        failures++;
        $display("FAIL a_missing cyc=%0d required data=%h due=%0d", cyc, sb[0].data, sb[0].due);
        void'(sb.pop_front());
      end
    end

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (a_valid !== 1'b0 || a_last !== 1'b0 || a_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_a got v=%b l=%b d=%h required 0", a_valid, a_last, a_data);
    end
    checks++;
    if (q0_valid !== 1'b0 || q0_data !== 24'h0 || q1_valid !== 1'b0 || q1_data !== 24'h0) begin
      failures++;
      $display("FAIL reset_q got v0=%b d0=%h v1=%b d1=%h required 0", q0_valid, q0_data, q1_valid, q1_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_geometry();
    int o0, l0;
    a_wt = {36{8'h01}};
    a_bias = '0;
    o0 = a_outs;
    l0 = a_lasts;
    for (int i = 0; i < 16; i++) cycle_a(1'b1, i == 0, {18{8'h01}});
    drain();
    checks++;
    if (a_outs - o0 != 4) begin
      failures++;
      $display("FAIL geom_count got=%0d required=4", a_outs - o0);
    end
    checks++;
    if (a_lasts - l0 != 1) begin
      failures++;
      $display("FAIL geom_last got=%0d required=1", a_lasts - l0);
    end
    checks++;
    if (a_data !== 16'h1212) begin
      failures++;
      $display("FAIL geom_hold got=%h required=1212", a_data);
    end
  endtask

  task automatic test_requant();
    logic [7:0] d[3];
    logic [23:0] e0[$], e1[$];
    d[0] = 8'h7F;
    d[1] = 8'hFB;
    d[2] = 8'h00;
    e0 = {24'h7F807F, 24'hF97F80, 24'h010000};
    e1 = {24'h7F007F, 24'h007F00, 24'h010000};
    q_wt = {8'h03, 8'h80, 8'h7F};
    q_bias = {8'h01, 8'h00, 8'h00};
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      q_v = i < 3;
      q_sof = i == 0;
      q_win = i < 3 ? d[i] : 8'h00;
      @(negedge clk);
      if (q0_valid) begin
        checks++;
        if (e0.size() == 0 || q0_data !== e0[0] || q0_last !== 1'b0) begin
          failures++;
          $display("FAIL requant_relu0 got=%h last=%b required=%h", q0_data, q0_last, e0.size() ? e0[0] : 24'h0);
        end
        if (e0.size() != 0) void'(e0.pop_front());
      end
      if (q1_valid) begin
        checks++;
        if (e1.size() == 0 || q1_data !== e1[0] || q1_last !== 1'b0) begin
          failures++;
          $display("FAIL requant_relu1 got=%h last=%b required=%h", q1_data, q1_last, e1.size() ? e1[0] : 24'h0);
        end
        if (e1.size() != 0) void'(e1.pop_front());
      end
    end
    checks++;
    if (e0.size() != 0 || e1.size() != 0) begin
      failures++;
      $display("FAIL requant_missing got pending=%0d/%0d required 0/0", e0.size(), e1.size());
    end
  endtask

  task automatic test_resync();
    int o0, l0;
    rand_params();
    o0 = a_outs;
    l0 = a_lasts;
    for (int i = 0; i < 22; i++) cycle_a(1'b1, i == 6, rand_win());
    drain();
    checks++;
    if (a_outs - o0 != 6 || a_lasts - l0 != 1) begin
      failures++;
      $display("FAIL resync got outs=%0d lasts=%0d required 6/1", a_outs - o0, a_lasts - l0);
    end
  endtask

  task automatic test_gapped();
    int o0, l0;
    rand_params();
    o0 = a_outs;
    l0 = a_lasts;
    for (int i = 0; i < 16; i++) begin
      cycle_a(1'b1, i == 0, rand_win());
      repeat ($urandom_range(3)) cycle_a(1'b0, 1'b0, '0);
    end
    drain();
    checks++;
    if (a_outs - o0 != 4 || a_lasts - l0 != 1) begin
      failures++;
      $display("FAIL gapped got outs=%0d lasts=%0d required 4/1", a_outs - o0, a_lasts - l0);
    end
  endtask

  task automatic test_reset_mid();
    int o0, l0;
    rand_params();
    for (int i = 0; i < 3; i++) cycle_a(1'b1, 1'b1, rand_win());
    cycle_a(1'b0, 1'b0, '0);
    checks++;
    if (a_valid !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre got v=%b required 1", a_valid);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (a_valid !== 1'b0 || a_last !== 1'b0 || a_data !== 16'h0) begin
      failures++;
      $display("FAIL rmid_async got v=%b l=%b d=%h required 0", a_valid, a_last, a_data);
    end
    sb.delete();
    mcol = 0;
    mrow = 0;
    #1 rst = 1'b0;
    o0 = a_outs;
    l0 = a_lasts;
    for (int i = 0; i < 16; i++) cycle_a(1'b1, 1'b0, rand_win());
    drain();
    checks++;
    if (a_outs - o0 != 4 || a_lasts - l0 != 1) begin
      failures++;
      $display("FAIL rmid_frame got outs=%0d lasts=%0d required 4/1", a_outs - o0, a_lasts - l0);
    end
  endtask

  initial begin
    a_win = '0;
    a_v = 1'b0;
    a_sof = 1'b0;
    a_wt = '0;
    a_bias = '0;
    q_win = '0;
    q_v = 1'b0;
    q_sof = 1'b0;
    q_wt = '0;
    q_bias = '0;
    test_reset();
    test_geometry();
    test_requant();
    test_resync();
    test_gapped();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_layer_ms.md
# conv_layer_ms

Parametrised convolution layer: multi-input-channel, true 2-D stride, fixed-point requantisation, optional ReLU. Consumes one K×K×ICH window per valid cycle in raster order from the upstream line buffer. Decimates windows by STRIDE in both row and column. Emits OCH requantised results per accepted window with fixed latency, feeding pooling or the next conv stage.

## Interface
- F, 28: input feature width/height. Window grid is W = F-KX+1 per side.
- B, 8: data/weight/bias/output width, signed two's complement.
- KX, 3: kernel width.
- KY, 3: kernel height.
- ICH, 1: input channels.
- OCH, 16: output channels.
- STRIDE, 2: spatial stride, ≥1.
- FRAC, 0: requantisation right-shift.
- RELU, 1: 1 = clamp negatives to 0.
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_window  in  ICH*KX*KY*B  window; element (c,y,x) at bits [((c*KY+y)*KX+x)*B +: B].
- i_window_valid  in  1  window present this cycle.
- i_sof  in  1  qualified by valid; this window is position (0,0).
- i_weight  in  OCH*ICH*KX*KY*B  element (o,c,y,x) at [(((o*ICH+c)*KY+y)*KX+x)*B +: B]; static during a frame.
- i_bias  in  OCH*B  bias o at [o*B +: B].
- o_data  out  OCH*B  channel o at [o*B +: B].
- o_valid  out  1  all OCH channels valid.
- o_last  out  1  with o_valid, marks final output of the frame.

## Operation
- Position counters col, row, each 0..W-1.
  - On each valid window: col++; at W-1, col wraps to 0 and row++; at row W-1 with col W-1, both wrap to 0.
  - Valid with i_sof: the window is treated as (0,0); counters then advance to (0,1). This overrides any count in progress.
- Accept rule: accept when valid and (col mod STRIDE)==0 and (row mod STRIDE)==0. Non-accepted windows produce nothing.
- Outputs per frame: OW×OW, where OW = (W-1)/STRIDE+1.
- Last position: LP = (OW-1)*STRIDE. The accepted window at (LP,LP) carries last=1.
- Arithmetic per channel o:
  - acc = Σ w(o,c,y,x)·d(c,y,x) + (bias_o <<< FRAC).
  - Accumulator width ACC = 2B + clog2(ICH*KX*KY+1) + 1. No overflow is possible.
- Requantisation:
  - r = acc >>> FRAC (arithmetic, truncation toward −∞).
  - If RELU and r<0, r = 0.
  - Saturate r to [−2^(B−1), 2^(B−1)−1].
- No backpressure. Upstream may present a valid window every cycle; throughput is one accepted window per cycle.

## Timing
- Latency 3 cycles from accepted window edge to o_valid:
  - S1: register the ICH*KX*KY products for each channel, plus accept and last tags.
  - S2: register the adder-tree sum plus bias.
  - S3: register the shifted, ReLU'd, saturated result to o_data, o_valid and o_last.
- Valid and last tags travel in a 3-deep shift register alongside the data.
- o_data holds its last value when o_valid=0.
- Reset (asynchronous, any time, including mid-pipeline):
  - col, row, pipeline registers, o_data, o_valid and o_last go to 0 immediately.
  - In-flight results are discarded.
  - First window after release is (0,0) whether or not i_sof is set.
- i_sof mid-pipeline: windows already accepted still complete and emit normally, including their last tags.
- Weight or bias changes take effect at S1/S2 capture. Changing them mid-frame is illegal.

## Structure
- Shared package cnn_pkg holds:
  - function clog2;
  - ACC width function;
  - saturating requantise function (acc, FRAC, RELU → B bits).
- Sub-module conv_pe: one output channel's 3-stage MAC/requantise pipeline, data path only.
- conv_layer_ms owns the counters, accept/last logic and valid pipeline, and generates OCH conv_pe instances.

## Test plan
- Geometry: F=6, K=3, STRIDE=2, ICH=2, all weights 1, all data 1, bias 0, FRAC=0, 16 back-to-back windows.
  - Exactly 4 outputs, at positions (0,0),(0,2),(2,0),(2,2).
  - Each output is 18 on every channel, 3 cycles after its window.
  - o_last set only on the 4th output.
- Saturation: data 127, weights 127, ICH=1 → 127. Data 127, weights −128 → −128 with RELU=0, 0 with RELU=1.
- Requantise: one tap, weight 3, datum −5, bias 1, FRAC=1, RELU=0 → acc = −15+2 = −13 → output −7.
- i_sof resync: assert i_sof on the 7th window of a frame. Counting restarts, and the next 4 accepted outputs follow the (0,0) pattern with last on the 4th.
- Gapped valid: random idle cycles between windows → same outputs and order as the back-to-back run, each exactly 3 cycles after its window.
- Reset mid-frame: pulse i_rst asynchronously while 2 results are in flight.
  - o_valid drops at once, and the in-flight results never appear.
  - Next frame starts at (0,0) without i_sof.
